carregador_programa: RTL and testbench

- Program loader between the simulated HD and the instruction memory (RAM).
- On request from the OS controller, it copies a block of 32-bit words from one HD track into instruction memory starting at address 0.
- It holds CPU-block asserted while copying and pulses a completion flag so the controller can deselect the BIOS and release the CPU.

---
 rtl/so_pkg.sv | 20 ++
 rtl/carregador_programa_contador_espera.sv | 27 ++
 rtl/carregador_programa.sv | 146 ++++++++++++++
 tb/tb_carregador_programa.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/so_pkg.sv
// Shared definitions for the OS-side blocks: HD geometry, instruction-memory
// size and the program loader state set.
package so_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned TRILHA_W     = 4;
    localparam int unsigned SETOR_W      = 6;
    localparam int unsigned MAX_PALAVRAS = 64;

    typedef enum logic [2:0] {
        OCIOSO,
        ENDERECA,
        ESPERA,
        GRAVA,
        FIM,
        ERRO
    } carregador_estado_t;

endpackage

// File: rtl/carregador_programa_contador_espera.sv
// Loadable down-counter with zero flag, used to wait out the HD read latency.
module contador_espera #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         carrega,
    input  logic [W-1:0] valor,
    input  logic         decrementa,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (carrega) begin
            cnt <= valor;
        end else if (decrementa && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/carregador_programa.sv
// Program loader: copies a block of words from one HD track into instruction
// memory from address 0, holding the CPU blocked while the copy runs.
module carregador_programa #(
    parameter int unsigned DATA_W   = so_pkg::DATA_W,
    parameter int unsigned ADDR_W   = so_pkg::ADDR_W,
    parameter int unsigned TRILHA_W = so_pkg::TRILHA_W,
    parameter int unsigned SETOR_W  = so_pkg::SETOR_W,
    parameter int unsigned HD_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inicio,
    input  logic [TRILHA_W-1:0] trilha_ini,
    input  logic [SETOR_W-1:0]  setor_ini,
    input  logic [ADDR_W:0]     n_palavras,
    input  logic [DATA_W-1:0]   hd_dado,
    output logic [TRILHA_W-1:0] hd_trilha,
    output logic [SETOR_W-1:0]  hd_setor,
    output logic                mi_we,
    output logic [ADDR_W-1:0]   mi_ender,
    output logic [DATA_W-1:0]   mi_dado,
    output logic                ocupado,
    output logic                bloq_cpu,
    output logic                pronto,
    output logic                erro
);

    import so_pkg::*;

    localparam int unsigned ESPERA_W = $clog2(HD_LAT) + 1;

    carregador_estado_t estado, prox;

    logic [ADDR_W:0]     idx, n_lat;
    logic [TRILHA_W-1:0] trilha_lat, trilha_q;
    logic [SETOR_W-1:0]  setor_lat, setor_q, setor_calc;
    logic [ADDR_W-1:0]   ender_q;
    logic [DATA_W-1:0]   dado_q;
    logic                pedido_ok, ultimo;
    logic                carrega, decrementa, espera_zero;

    assign pedido_ok  = (n_palavras != '0) && (n_palavras <= (ADDR_W+1)'(MAX_PALAVRAS));
    // idx is one bit wider than the address so a full 64-word block terminates
    assign ultimo     = ((idx + 1'b1) == n_lat);
    assign setor_calc = setor_lat + SETOR_W'(idx);

    contador_espera #(
        .W (ESPERA_W)
    ) u_espera (
        .clk        (clk),
        .reset      (reset),
        .carrega    (carrega),
        .valor      (ESPERA_W'(HD_LAT - 1)),
        .decrementa (decrementa),
        .zero       (espera_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado     <= OCIOSO;
            idx        <= '0;
            n_lat      <= '0;
            trilha_lat <= '0;
            setor_lat  <= '0;
            trilha_q   <= '0;
            setor_q    <= '0;
            ender_q    <= '0;
            dado_q     <= '0;
        end else begin
            estado <= prox;
            case (estado)
                OCIOSO: begin
                    if (inicio && pedido_ok) begin
                        trilha_lat <= trilha_ini;
                        setor_lat  <= setor_ini;
                        n_lat      <= n_palavras;
                        idx        <= '0;
                    end
                end
                ENDERECA: begin
                    trilha_q <= trilha_lat;
                    setor_q  <= setor_calc;
                end
                GRAVA: begin
                    ender_q <= idx[ADDR_W-1:0];
                    dado_q  <= hd_dado;
                    idx     <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Address/data outputs show the live value in their active state and the
    // registered copy elsewhere, so they hold between words and in OCIOSO.
    always_comb begin
        prox       = estado;
        hd_trilha  = trilha_q;
        hd_setor   = setor_q;
        mi_we      = 1'b0;
        mi_ender   = ender_q;
        mi_dado    = dado_q;
        pronto     = 1'b0;
        erro       = 1'b0;
        carrega    = 1'b0;
        decrementa = 1'b0;
        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    prox = pedido_ok ? ENDERECA : ERRO;
                end
            end
            ENDERECA: begin
                hd_trilha = trilha_lat;
                hd_setor  = setor_calc;
                carrega   = 1'b1;
                prox      = ESPERA;
            end
            ESPERA: begin
                decrementa = 1'b1;
                if (espera_zero) begin
                    prox = GRAVA;
                end
            end
            GRAVA: begin
                mi_we    = 1'b1;
                mi_ender = idx[ADDR_W-1:0];
                mi_dado  = hd_dado;
                prox     = ultimo ? FIM : ENDERECA;
            end
            FIM: begin
                pronto = 1'b1;
                prox   = OCIOSO;
            end
            ERRO: begin
                erro = 1'b1;
                prox = OCIOSO;
            end
            default: prox = OCIOSO;
        endcase
    end

    assign ocupado  = (estado != OCIOSO);
    assign bloq_cpu = ocupado;

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench: two loaders (HD latency 1 and 3) driven against an HD
// image model, with cycle-exact expectations derived from the transfer rules.
module tb_carregador_programa;

    logic        clk;
    logic        reset      [2];
    logic        inicio     [2];
    logic [3:0]  trilha_ini [2];
    logic [5:0]  setor_ini  [2];
    logic [6:0]  n_palavras [2];
    logic [31:0] hd_dado    [2];
    logic [3:0]  hd_trilha  [2];
    logic [5:0]  hd_setor   [2];
    logic        mi_we      [2];
    logic [5:0]  mi_ender   [2];
    logic [31:0] mi_dado    [2];
    logic        ocupado    [2];
    logic        bloq_cpu   [2];
    logic        pronto     [2];
    logic        erro       [2];

    int errors = 0;
    int checks = 0;

    logic [31:0] hd_img [16][64];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    logic [31:0] mem_m  [2][64];
    int          wr_cnt [2] = '{0, 0};

    carregador_programa #(.DATA_W(32), .ADDR_W(6), .TRILHA_W(4), .SETOR_W(6), .HD_LAT(1)) dut_a (
        .clk(clk), .reset(reset[0]), .inicio(inicio[0]), .trilha_ini(trilha_ini[0]),
        .setor_ini(setor_ini[0]), .n_palavras(n_palavras[0]), .hd_dado(hd_dado[0]),
        .hd_trilha(hd_trilha[0]), .hd_setor(hd_setor[0]), .mi_we(mi_we[0]),
        .mi_ender(mi_ender[0]), .mi_dado(mi_dado[0]), .ocupado(ocupado[0]),
        .bloq_cpu(bloq_cpu[0]), .pronto(pronto[0]), .erro(erro[0])
    );

    carregador_programa #(.DATA_W(32), .ADDR_W(6), .TRILHA_W(4), .SETOR_W(6), .HD_LAT(3)) dut_b (
        .clk(clk), .reset(reset[1]), .inicio(inicio[1]), .trilha_ini(trilha_ini[1]),
        .setor_ini(setor_ini[1]), .n_palavras(n_palavras[1]), .hd_dado(hd_dado[1]),
        .hd_trilha(hd_trilha[1]), .hd_setor(hd_setor[1]), .mi_we(mi_we[1]),
        .mi_ender(mi_ender[1]), .mi_dado(mi_dado[1]), .ocupado(ocupado[1]),
        .bloq_cpu(bloq_cpu[1]), .pronto(pronto[1]), .erro(erro[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // HD: data for the addressed sector appears HD_LAT cycles later
    always @(posedge clk) begin
        pipe_a    <= hd_img[hd_trilha[0]][hd_setor[0]];
        pipe_b[0] <= hd_img[hd_trilha[1]][hd_setor[1]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign hd_dado[0] = pipe_a;
    assign hd_dado[1] = pipe_b[2];

    // Instruction memory
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mi_we[d] === 1'b1) begin
                mem_m[d][mi_ender[d]] <= mi_dado[d];
                wr_cnt[d] <= wr_cnt[d] + 1;
            end
        end
    end

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [3:0] tr, input logic [5:0] se, input int w);
        logic [5:0] s;
        s = se + 6'(w);
        return hd_img[tr][s];
    endfunction

    task automatic chk_zero(input int d);
        chk(d, "rst_ocupado",  32'(ocupado[d]),   '0);
        chk(d, "rst_bloq",     32'(bloq_cpu[d]),  '0);
        chk(d, "rst_pronto",   32'(pronto[d]),    '0);
        chk(d, "rst_erro",     32'(erro[d]),      '0);
        chk(d, "rst_mi_we",    32'(mi_we[d]),     '0);
        chk(d, "rst_mi_ender", 32'(mi_ender[d]),  '0);
        chk(d, "rst_mi_dado",  mi_dado[d],        '0);
        chk(d, "rst_trilha",   32'(hd_trilha[d]), '0);
        chk(d, "rst_setor",    32'(hd_setor[d]),  '0);
    endtask

    task automatic run_copy(input int d, input logic [3:0] tr, input logic [5:0] se,
                            input int n, input bit intrude, input bit abort);
        int lat, p, w, ph, wr0;
        logic [5:0] sec;
        lat = (d == 0) ? 1 : 3;
        p   = 2 + lat;
        @(negedge clk);
        trilha_ini[d] = tr;
        setor_ini[d]  = se;
        n_palavras[d] = 7'(n);
        inicio[d]     = 1'b1;
        wr0 = wr_cnt[d];
        @(negedge clk);
        inicio[d] = 1'b0;
        for (int c = 1; c <= n * p + 2; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= n * p) begin
                w   = (c - 1) / p;
                ph  = (c - 1) % p;
                sec = se + 6'(w);
                chk(d, "ocupado", 32'(ocupado[d]),  32'd1);
                chk(d, "bloq",    32'(bloq_cpu[d]), 32'd1);
                chk(d, "pronto",  32'(pronto[d]),   32'd0);
                chk(d, "erro",    32'(erro[d]),     32'd0);
                chk(d, "mi_we",   32'(mi_we[d]),    32'(ph == p - 1));
                chk(d, "trilha",  32'(hd_trilha[d]), 32'(tr));
                chk(d, "setor",   32'(hd_setor[d]),  32'(sec));
                if (ph == p - 1) begin
                    chk(d, "mi_ender", 32'(mi_ender[d]), 32'(w));
                    chk(d, "mi_dado",  mi_dado[d],       exp_word(tr, se, w));
                end else if (w > 0) begin
                    chk(d, "ender_hold", 32'(mi_ender[d]), 32'(w - 1));
                    chk(d, "dado_hold",  mi_dado[d],       exp_word(tr, se, w - 1));
                end
                if (abort && w == 1 && ph == 1) begin
                    #2 reset[d] = 1'b0;
                    #1 chk_zero(d);
                    repeat (2) begin
                        @(negedge clk);
                        chk(d, "abort_pronto",  32'(pronto[d]),  32'd0);
                        chk(d, "abort_ocupado", 32'(ocupado[d]), 32'd0);
                    end
                    reset[d] = 1'b1;
                    chk(d, "abort_writes", 32'(wr_cnt[d] - wr0), 32'd1);
                    chk(d, "abort_mem0",   mem_m[d][0],          exp_word(tr, se, 0));
                    return;
                end
            end else if (c == n * p + 1) begin
                chk(d, "fim_pronto",  32'(pronto[d]),   32'd1);
                chk(d, "fim_ocupado", 32'(ocupado[d]),  32'd1);
                chk(d, "fim_bloq",    32'(bloq_cpu[d]), 32'd1);
                chk(d, "fim_mi_we",   32'(mi_we[d]),    32'd0);
                chk(d, "fim_erro",    32'(erro[d]),     32'd0);
            end else begin
                chk(d, "idle_ocupado", 32'(ocupado[d]),  32'd0);
                chk(d, "idle_bloq",    32'(bloq_cpu[d]), 32'd0);
                chk(d, "idle_pronto",  32'(pronto[d]),   32'd0);
            end
            if (intrude && c == 2) begin
                inicio[d]     = 1'b1;
                trilha_ini[d] = ~tr;
                setor_ini[d]  = se + 6'd7;
                n_palavras[d] = 7'd2;
            end
            if (intrude && c == 5) inicio[d] = 1'b0;
        end
        chk(d, "n_writes", 32'(wr_cnt[d] - wr0), 32'(n));
        for (int i = 0; i < n; i++) chk(d, "mem", mem_m[d][i], exp_word(tr, se, i));
    endtask

    task automatic run_err(input int d, input logic [6:0] n);
        logic [3:0] tr0;
        logic [5:0] se0;
        int wr0;
        tr0 = hd_trilha[d];
        se0 = hd_setor[d];
        wr0 = wr_cnt[d];
        @(negedge clk);
        trilha_ini[d] = 4'($urandom_range(0, 15));
        setor_ini[d]  = 6'($urandom_range(0, 63));
        n_palavras[d] = n;
        inicio[d]     = 1'b1;
        @(negedge clk);
        inicio[d] = 1'b0;
        chk(d, "err_erro",    32'(erro[d]),      32'd1);
        chk(d, "err_ocupado", 32'(ocupado[d]),   32'd1);
        chk(d, "err_bloq",    32'(bloq_cpu[d]),  32'd1);
        chk(d, "err_pronto",  32'(pronto[d]),    32'd0);
        chk(d, "err_mi_we",   32'(mi_we[d]),     32'd0);
        chk(d, "err_trilha",  32'(hd_trilha[d]), 32'(tr0));
        chk(d, "err_setor",   32'(hd_setor[d]),  32'(se0));
        @(negedge clk);
        chk(d, "err_erro_off",    32'(erro[d]),    32'd0);
        chk(d, "err_ocupado_off", 32'(ocupado[d]), 32'd0);
        chk(d, "err_writes",      32'(wr_cnt[d] - wr0), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0;
            inicio[d] = 1'b0;
            trilha_ini[d] = '0;
            setor_ini[d] = '0;
            n_palavras[d] = '0;
        end
        for (int t = 0; t < 16; t++)
            for (int s = 0; s < 64; s++)
                hd_img[t][s] = (t == 2) ? 32'hA0 + 32'(s) : $urandom;

        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        reset[0] = 1'b1;
        reset[1] = 1'b1;
        @(negedge clk);
        chk_zero(0);
        chk_zero(1);

        run_copy(0, 4'd2, 6'd5, 3, 1'b0, 1'b0);
        run_copy(0, 4'($urandom_range(0, 15)), 6'd62, 4, 1'b0, 1'b0);
        run_err(0, 7'd0);
        run_err(0, 7'd65);
        run_err(0, 7'd127);
        run_copy(0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 64, 1'b0, 1'b0);
        run_copy(0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 5, 1'b1, 1'b0);
        run_copy(0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 4, 1'b0, 1'b1);
        run_copy(0, 4'd2, 6'd5, 3, 1'b0, 1'b0);
        repeat (3) run_copy(0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                            int'($urandom_range(1, 64)), 1'b0, 1'b0);

        run_copy(1, 4'd2, 6'd5, 3, 1'b0, 1'b0);
        run_copy(1, 4'($urandom_range(0, 15)), 6'd62, 4, 1'b0, 1'b0);
        run_err(1, 7'd65);
        run_copy(1, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 4, 1'b0, 1'b1);
        run_copy(1, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 6, 1'b0, 1'b0);
        run_copy(1, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 64, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
